// File: rtl/ahb_lite_master_bridge.sv
// AHB-Lite single-master bridge: command FIFO feeding a pipelined address/data
// phase engine that issues SINGLE transfers and replays after an ERROR response.
module ahb_lite_master_bridge #(
    parameter int         BUS_WIDTH      = 32,
    parameter int         CMD_FIFO_DEPTH = 4,
    parameter logic [3:0] HPROT_VALUE    = 4'b0011
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [BUS_WIDTH-1:0] cmd_addr,
    input  logic [2:0]           cmd_size,
    input  logic [BUS_WIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic [BUS_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [BUS_WIDTH-1:0] HADDR,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [3:0]           HPROT,
    output logic [1:0]           HTRANS,
    output logic                 HMASTLOCK,
    output logic [BUS_WIDTH-1:0] HWDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    input  logic [BUS_WIDTH-1:0] HRDATA
);

    localparam int         AW        = $clog2(CMD_FIFO_DEPTH);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef struct packed {
        logic                 write;
        logic [BUS_WIDTH-1:0] addr;
        logic [2:0]           size;
        logic [BUS_WIDTH-1:0] wdata;
    } cmd_t;

    cmd_t                 r_fifo [CMD_FIFO_DEPTH];
    logic [AW:0]          r_wrPtr, r_rdPtr;
    logic                 r_aValid, r_aLerr, r_aWrite;
    logic [BUS_WIDTH-1:0] r_aAddr, r_aWdata;
    logic [2:0]           r_aSize;
    logic                 r_dValid, r_dLerr, r_dWrite;
    logic [BUS_WIDTH-1:0] r_dWdata;
    logic [1:0]           r_htrans;
    logic                 r_replay;
    logic                 r_rspValid, r_rspWrite, r_rspErr;
    logic [BUS_WIDTH-1:0] r_rspRdata;

    cmd_t w_head;
    logic w_empty, w_full, w_push, w_headLerr;
    logic w_errStart, w_replayEdge, w_advance, w_loadA, w_complete;
    logic w_nextAValid, w_nextALerr;

    assign w_empty   = (r_wrPtr == r_rdPtr);
    assign w_full    = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_head    = r_fifo[r_rdPtr[AW-1:0]];

    assign HADDR     = r_aAddr;
    assign HWRITE    = r_aWrite;
    assign HSIZE     = r_aSize;
    assign HTRANS    = r_htrans;
    assign HWDATA    = r_dWdata;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VALUE;
    assign HMASTLOCK = 1'b0;
    assign rsp_valid = r_rspValid;
    assign rsp_write = r_rspWrite;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;

    // Unsupported sizes and misaligned addresses never reach the bus.
    always_comb begin
        w_headLerr = 1'b1;
        case (w_head.size)
            3'd0:    w_headLerr = 1'b0;
            3'd1:    w_headLerr = w_head.addr[0];
            3'd2:    w_headLerr = |w_head.addr[1:0];
            default: w_headLerr = 1'b1;
        endcase
    end

    // After an ERROR the cancelled A-stage command was never seen by the slave,
    // so the edge ending the error response re-issues it instead of advancing it.
    always_comb begin
        w_errStart   = !HREADY && HRESP && r_dValid && !r_replay;
        w_replayEdge = HREADY && r_replay;
        w_advance    = HREADY && !r_replay;
        w_loadA      = !w_empty && (w_advance || (w_replayEdge && !r_aValid));
        w_complete   = HREADY && r_dValid;
        w_nextAValid = r_aValid;
        w_nextALerr  = r_aLerr;
        if (w_loadA) begin
            w_nextAValid = 1'b1;
            w_nextALerr  = w_headLerr;
        end else if (w_advance) begin
            w_nextAValid = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push)
            r_fifo[r_wrPtr[AW-1:0]] <= {cmd_write, cmd_addr, cmd_size, cmd_wdata};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_aValid   <= 1'b0;
            r_aLerr    <= 1'b0;
            r_aWrite   <= 1'b0;
            r_aAddr    <= '0;
            r_aSize    <= '0;
            r_aWdata   <= '0;
            r_dValid   <= 1'b0;
            r_dLerr    <= 1'b0;
            r_dWrite   <= 1'b0;
            r_dWdata   <= '0;
            r_htrans   <= TR_IDLE;
            r_replay   <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspWrite <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + {{AW{1'b0}}, 1'b1};
            if (w_loadA) begin
                r_rdPtr  <= r_rdPtr + {{AW{1'b0}}, 1'b1};
                r_aWrite <= w_head.write;
                r_aAddr  <= w_head.addr;
                r_aSize  <= w_head.size;
                r_aWdata <= w_head.wdata;
            end
            r_aValid <= w_nextAValid;
            r_aLerr  <= w_nextALerr;

            if (w_errStart)
                r_htrans <= TR_IDLE;
            else if (HREADY)
                r_htrans <= (w_nextAValid && !w_nextALerr) ? TR_NONSEQ : TR_IDLE;

            if (w_advance) begin
                r_dValid <= r_aValid;
                r_dLerr  <= r_aLerr;
                r_dWrite <= r_aWrite;
                r_dWdata <= r_aWdata;
            end else if (w_replayEdge) begin
                r_dValid <= 1'b0;
            end

            if (w_errStart)
                r_replay <= 1'b1;
            else if (w_replayEdge)
                r_replay <= 1'b0;

            r_rspValid <= w_complete;
            if (w_complete) begin
                r_rspWrite <= r_dWrite;
                r_rspErr   <= HRESP || r_dLerr;
                r_rspRdata <= (!r_dWrite && !r_dLerr) ? HRDATA : '0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Directed bench for ahb_lite_master_bridge; the bench plays the AHB slave by
// driving HREADY/HRESP/HRDATA cycle by cycle against hand-computed expectations.
module tb_ahb_lite_master_bridge;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    int checkCount  = 0;
    int errorCount  = 0;
    int rspCount    = 0;
    int nonseqCount = 0;
    int rspStart, nsStart;

    ahb_lite_master_bridge #(
        .BUS_WIDTH(32), .CMD_FIFO_DEPTH(4), .HPROT_VALUE(4'b0011)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (rsp_valid) rspCount++;
        if (HTRANS == 2'b10) nonseqCount++;
    end

    task automatic step;
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata);
        cmd_valid = valid;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_size  = size;
        cmd_wdata = wdata;
    endtask

    task automatic setBus(input logic ready, input logic resp, input logic [31:0] rdata);
        HREADY = ready;
        HRESP  = resp;
        HRDATA = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        HRESETn = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        setBus(1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("rst_htrans",    32'(HTRANS),    32'h0);
        checkOutput("rst_haddr",     HADDR,          32'h0);
        checkOutput("rst_hwdata",    HWDATA,         32'h0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_rdata", rsp_rdata,      32'h0);
        checkOutput("hburst",        32'(HBURST),    32'h0);
        checkOutput("hprot",         32'(HPROT),     32'h3);
        checkOutput("hmastlock",     32'(HMASTLOCK), 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step;

        $display("[TB] single write");
        setBus(1'b1, 1'b0, 32'h0BADF00D);
        applyStimulus(1'b1, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        step;
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        checkOutput("t1_idle_in_fifo", 32'(HTRANS), 32'h0);
        step;
        checkOutput("t1_htrans", 32'(HTRANS), 32'h2);
        checkOutput("t1_haddr",  HADDR,       32'h10);
        checkOutput("t1_hwrite", 32'(HWRITE), 32'h1);
        checkOutput("t1_hsize",  32'(HSIZE),  32'h2);
        step;
        checkOutput("t1_hwdata",     HWDATA,         32'hDEADBEEF);
        checkOutput("t1_htrans_idle", 32'(HTRANS),   32'h0);
        checkOutput("t1_no_rsp_yet", 32'(rsp_valid), 32'h0);
        step;
        checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t1_rsp_err",   32'(rsp_err),   32'h0);
        checkOutput("t1_rsp_rdata", rsp_rdata,      32'h0);
        checkOutput("t1_rsp_write", 32'(rsp_write), 32'h1);
        step;
        checkOutput("t1_rsp_pulse", 32'(rsp_valid), 32'h0);

        $display("[TB] back-to-back reads");
        for (int i = 0; i < 7; i++) begin
            if (i < 4) applyStimulus(1'b1, 1'b0, 32'(4 * i), 3'd2, 32'h0);
            else       applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
            HRDATA = (i >= 3) ? 32'h100 + 32'(4 * (i - 3)) : 32'h0;
            step;
            if (i >= 1 && i <= 4) begin
                checkOutput("t2_htrans", 32'(HTRANS), 32'h2);
                checkOutput("t2_haddr",  HADDR,       32'(4 * (i - 1)));
            end
            if (i >= 3) begin
                checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'h1);
                checkOutput("t2_rsp_rdata", rsp_rdata,      32'h100 + 32'(4 * (i - 3)));
            end else begin
                checkOutput("t2_no_rsp", 32'(rsp_valid), 32'h0);
            end
        end
        checkOutput("t2_idle_after", 32'(HTRANS), 32'h0);
        setBus(1'b1, 1'b0, 32'h0);
        step;

        $display("[TB] wait states");
        applyStimulus(1'b1, 1'b1, 32'h40, 3'd2, 32'h11112222);
        step;
        applyStimulus(1'b1, 1'b0, 32'h44, 3'd2, 32'h0);
        step;
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        checkOutput("t3_haddr_w", HADDR, 32'h40);
        step;
        checkOutput("t3_haddr_r", HADDR,  32'h44);
        checkOutput("t3_hwdata",  HWDATA, 32'h11112222);
        setBus(1'b0, 1'b0, 32'h0);
        for (int w = 0; w < 2; w++) begin
            step;
            checkOutput("t3_wait_haddr",  HADDR,          32'h44);
            checkOutput("t3_wait_htrans", 32'(HTRANS),    32'h2);
            checkOutput("t3_wait_hwdata", HWDATA,         32'h11112222);
            checkOutput("t3_wait_no_rsp", 32'(rsp_valid), 32'h0);
        end
        setBus(1'b1, 1'b0, 32'h0);
        step;
        checkOutput("t3_wr_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t3_wr_rsp_write", 32'(rsp_write), 32'h1);
        checkOutput("t3_wr_rsp_err",   32'(rsp_err),   32'h0);
        setBus(1'b1, 1'b0, 32'hCAFE0044);
        step;
        checkOutput("t3_rd_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t3_rd_rsp_rdata", rsp_rdata,      32'hCAFE0044);
        setBus(1'b1, 1'b0, 32'h0);
        step;

        $display("[TB] bus error with replay");
        rspStart = rspCount;
        applyStimulus(1'b1, 1'b0, 32'h20, 3'd2, 32'h0);
        step;
        applyStimulus(1'b1, 1'b0, 32'h24, 3'd2, 32'h0);
        step;
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        step;
        checkOutput("t4_haddr_r1", HADDR, 32'h24);
        setBus(1'b0, 1'b1, 32'h0);
        step;
        checkOutput("t4_htrans_cancel", 32'(HTRANS),    32'h0);
        checkOutput("t4_no_rsp_yet",    32'(rsp_valid), 32'h0);
        setBus(1'b1, 1'b1, 32'h0);
        step;
        checkOutput("t4_err_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t4_err_rsp_err",   32'(rsp_err),   32'h1);
        checkOutput("t4_replay_htrans", 32'(HTRANS),    32'h2);
        checkOutput("t4_replay_haddr",  HADDR,          32'h24);
        setBus(1'b1, 1'b0, 32'h0);
        step;
        checkOutput("t4_gap_no_rsp", 32'(rsp_valid), 32'h0);
        setBus(1'b1, 1'b0, 32'h00000055);
        step;
        checkOutput("t4_r1_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t4_r1_rsp_err",   32'(rsp_err),   32'h0);
        checkOutput("t4_r1_rsp_rdata", rsp_rdata,      32'h55);
        setBus(1'b1, 1'b0, 32'h0);
        step;
        step;
        checkOutput("t4_rsp_count", 32'(rspCount - rspStart), 32'h2);

        $display("[TB] local errors");
        rspStart = rspCount;
        nsStart  = nonseqCount;
        setBus(1'b1, 1'b0, 32'hFFFFFFFF);
        applyStimulus(1'b1, 1'b0, 32'h3, 3'd1, 32'h0);
        step;
        applyStimulus(1'b1, 1'b1, 32'h0, 3'd3, 32'h12345678);
        step;
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        step;
        step;
        checkOutput("t5_l0_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t5_l0_rsp_err",   32'(rsp_err),   32'h1);
        checkOutput("t5_l0_rsp_write", 32'(rsp_write), 32'h0);
        checkOutput("t5_l0_rsp_rdata", rsp_rdata,      32'h0);
        step;
        checkOutput("t5_l1_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t5_l1_rsp_err",   32'(rsp_err),   32'h1);
        checkOutput("t5_l1_rsp_write", 32'(rsp_write), 32'h1);
        step;
        checkOutput("t5_no_nonseq", 32'(nonseqCount - nsStart), 32'h0);
        checkOutput("t5_rsp_count", 32'(rspCount - rspStart),   32'h2);

        $display("[TB] fifo full and reset");
        setBus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h80, 3'd2, 32'hA0);
        step;
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        step;
        checkOutput("t6_c0_htrans", 32'(HTRANS), 32'h2);
        checkOutput("t6_c0_haddr",  HADDR,       32'h80);
        setBus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h84 + 32'(4 * i), 3'd2, 32'(i));
            #1;
            checkOutput("t6_cmd_ready", 32'(cmd_ready), (i < 4) ? 32'h1 : 32'h0);
            step;
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        checkOutput("t6_held_htrans", 32'(HTRANS), 32'h2);
        rspStart = rspCount;
        #2;
        HRESETn = 1'b0;
        #1;
        checkOutput("t6_rst_htrans",    32'(HTRANS),    32'h0);
        checkOutput("t6_rst_haddr",     HADDR,          32'h0);
        checkOutput("t6_rst_hwrite",    32'(HWRITE),    32'h0);
        checkOutput("t6_rst_hsize",     32'(HSIZE),     32'h0);
        checkOutput("t6_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        checkOutput("t6_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        setBus(1'b1, 1'b0, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        nsStart = nonseqCount;
        repeat (8) step;
        checkOutput("t6_no_rsp_after_rst",    32'(rspCount - rspStart),   32'h0);
        checkOutput("t6_no_nonseq_after_rst", 32'(nonseqCount - nsStart), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
